// File: rtl/regf_wbu.sv
// ---------------------------------------------------------------------------
// regf_wbu -- register-file write-back unit with pending-write scoreboard.
//
// Tracks which architectural registers have an in-flight write (pend bits),
// gates instruction issue on write-after-write conflicts, arbitrates between
// the load unit and the ALU for the single register-file write port, and
// forwards the value being committed this cycle to the hazard query ports.
//
// Ports
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_iss_valid/wen/rd           issuing instruction; o_iss_ready accepts it
//   i_exu_valid/rd/data          ALU result;  o_exu_ready accepts it
//   i_lsu_valid/rd/data          load result; o_lsu_ready accepts it
//   o_wb_en/waddr/wdata          register-file write port (registered)
//   i_rs1_addr, i_rs2_addr       hazard query addresses
//   o_rsX_busy                   source still waits on an uncommitted write
//   o_rsX_fwd, o_rsX_fwd_data    source value available from the write port
//   o_idle                       nothing pending and no write in progress
//   o_err                        sticky: result for a non-pending register
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on the same channel's valid; payload is only
// looked at while valid is high, and need not be held after acceptance.
// ---------------------------------------------------------------------------
module regf_wbu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int REG_NUM = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_iss_valid,
    input  logic              i_iss_wen,
    input  logic [ADDR_W-1:0] i_iss_rd,
    output logic              o_iss_ready,
    input  logic              i_exu_valid,
    input  logic [ADDR_W-1:0] i_exu_rd,
    input  logic [DATA_W-1:0] i_exu_data,
    output logic              o_exu_ready,
    input  logic              i_lsu_valid,
    input  logic [ADDR_W-1:0] i_lsu_rd,
    input  logic [DATA_W-1:0] i_lsu_data,
    output logic              o_lsu_ready,
    output logic              o_wb_en,
    output logic [ADDR_W-1:0] o_wb_waddr,
    output logic [DATA_W-1:0] o_wb_wdata,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    output logic              o_rs1_fwd,
    output logic              o_rs2_fwd,
    output logic [DATA_W-1:0] o_rs1_fwd_data,
    output logic [DATA_W-1:0] o_rs2_fwd_data,
    output logic              o_idle,
    output logic              o_err
);

    // Bit 0 exists only so every address can index the vector; it is forced
    // to zero on every update and never set.
    logic [REG_NUM-1:0] pend;
    logic [REG_NUM-1:0] pend_nxt;

    logic              iss_set;
    logic              res_valid;
    logic [ADDR_W-1:0] res_rd;
    logic [DATA_W-1:0] res_data;
    logic              res_write;
    logic              res_orphan;

    // A register whose pending write commits this cycle is free to be
    // claimed again: the clear and the new set land on the same edge.
    assign o_iss_ready = ~i_iss_wen | (i_iss_rd == '0) | ~pend[i_iss_rd] |
                         (o_wb_en & (o_wb_waddr == i_iss_rd));
    assign iss_set     = i_iss_valid & o_iss_ready & i_iss_wen & (i_iss_rd != '0);

    // Loads win the write port; the ALU retries while a load is offered.
    assign o_lsu_ready = 1'b1;
    assign o_exu_ready = ~i_lsu_valid;

    assign res_valid = i_lsu_valid | i_exu_valid;
    assign res_rd    = i_lsu_valid ? i_lsu_rd   : i_exu_rd;
    assign res_data  = i_lsu_valid ? i_lsu_data : i_exu_data;
    assign res_write = res_valid & (res_rd != '0);

    // A result is orphaned if nobody claimed its register, unless the claim
    // is being made in this very cycle.
    assign res_orphan = res_write & ~pend[res_rd] &
                        ~(iss_set & (i_iss_rd == res_rd));

    // Clear on commit first, then set on issue so a same-cycle set wins.
    always_comb begin
        pend_nxt = pend;
        if (o_wb_en) begin
            pend_nxt[o_wb_waddr] = 1'b0;
        end
        if (iss_set) begin
            pend_nxt[i_iss_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pend       <= '0;
            o_wb_en    <= 1'b0;
            o_wb_waddr <= '0;
            o_wb_wdata <= '0;
            o_err      <= 1'b0;
        end else begin
            pend    <= pend_nxt;
            o_wb_en <= res_write;
            // Address/data hold their last value unless a real write happens;
            // a result for x0 is consumed without touching the port.
            if (res_write) begin
                o_wb_waddr <= res_rd;
                o_wb_wdata <= res_data;
            end
            if (res_orphan) begin
                o_err <= 1'b1;
            end
        end
    end

    // Forwarding from the write port; x0 is never forwarded nor busy.
    assign o_rs1_fwd      = o_wb_en & (o_wb_waddr == i_rs1_addr) & (i_rs1_addr != '0);
    assign o_rs2_fwd      = o_wb_en & (o_wb_waddr == i_rs2_addr) & (i_rs2_addr != '0);
    assign o_rs1_fwd_data = o_rs1_fwd ? o_wb_wdata : '0;
    assign o_rs2_fwd_data = o_rs2_fwd ? o_wb_wdata : '0;
    assign o_rs1_busy     = pend[i_rs1_addr] & ~o_rs1_fwd;
    assign o_rs2_busy     = pend[i_rs2_addr] & ~o_rs2_fwd;

    assign o_idle = ~(|pend) & ~o_wb_en;

endmodule

// File: tb/tb_regf_wbu.sv
// ---------------------------------------------------------------------------
// tb_regf_wbu -- self-checking bench for regf_wbu.
// A bench-side model (set of claimed registers plus the write expected on
// the port next cycle) is advanced on each rising edge; a compare process
// checks every output against it on each falling edge. Directed sequences
// drive the scenarios and add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_regf_wbu;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int RN = 16;

    // ---------------- clock / reset ----------------
    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- DUT signals ----------------
    logic          i_iss_valid, i_iss_wen;
    logic [AW-1:0] i_iss_rd;
    logic          o_iss_ready;
    logic          i_exu_valid;
    logic [AW-1:0] i_exu_rd;
    logic [DW-1:0] i_exu_data;
    logic          o_exu_ready;
    logic          i_lsu_valid;
    logic [AW-1:0] i_lsu_rd;
    logic [DW-1:0] i_lsu_data;
    logic          o_lsu_ready;
    logic          o_wb_en;
    logic [AW-1:0] o_wb_waddr;
    logic [DW-1:0] o_wb_wdata;
    logic [AW-1:0] i_rs1_addr, i_rs2_addr;
    logic          o_rs1_busy, o_rs2_busy, o_rs1_fwd, o_rs2_fwd;
    logic [DW-1:0] o_rs1_fwd_data, o_rs2_fwd_data;
    logic          o_idle, o_err;

    regf_wbu #(.DATA_W(DW), .ADDR_W(AW), .REG_NUM(RN)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_iss_valid(i_iss_valid), .i_iss_wen(i_iss_wen), .i_iss_rd(i_iss_rd),
        .o_iss_ready(o_iss_ready),
        .i_exu_valid(i_exu_valid), .i_exu_rd(i_exu_rd), .i_exu_data(i_exu_data),
        .o_exu_ready(o_exu_ready),
        .i_lsu_valid(i_lsu_valid), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
        .o_lsu_ready(o_lsu_ready),
        .o_wb_en(o_wb_en), .o_wb_waddr(o_wb_waddr), .o_wb_wdata(o_wb_wdata),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
        .o_rs1_fwd(o_rs1_fwd), .o_rs2_fwd(o_rs2_fwd),
        .o_rs1_fwd_data(o_rs1_fwd_data), .o_rs2_fwd_data(o_rs2_fwd_data),
        .o_idle(o_idle), .o_err(o_err)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model state: which registers are claimed, and the write on the port.
    bit            m_claimed[RN];
    bit            m_wb_en;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_err;

    function automatic bit m_iss_ok();
        if (!i_iss_wen || i_iss_rd == 0) return 1;
        if (!m_claimed[i_iss_rd]) return 1;
        return m_wb_en && (m_waddr == i_iss_rd);
    endfunction

    function automatic bit m_fwd(input logic [AW-1:0] a);
        return m_wb_en && a != 0 && m_waddr == a;
    endfunction

    function automatic bit m_any_claimed();
        foreach (m_claimed[i]) if (m_claimed[i]) return 1;
        return 0;
    endfunction

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            foreach (m_claimed[i]) m_claimed[i] = 0;
            m_wb_en = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
        end else begin
            bit            claim;
            bit            got;
            logic [AW-1:0] rd;
            logic [DW-1:0] d;
            claim = i_iss_valid && m_iss_ok() && i_iss_wen && i_iss_rd != 0;
            got = 1;
            if (i_lsu_valid) begin rd = i_lsu_rd; d = i_lsu_data; end
            else if (i_exu_valid) begin rd = i_exu_rd; d = i_exu_data; end
            else begin got = 0; rd = '0; d = '0; end
            if (got && rd != 0 && !m_claimed[rd] && !(claim && i_iss_rd == rd))
                m_err = 1;
            // Committed write retires its claim; a fresh claim overrides.
            if (m_wb_en) m_claimed[m_waddr] = 0;
            if (claim) m_claimed[i_iss_rd] = 1;
            m_wb_en = got && rd != 0;
            if (m_wb_en) begin m_waddr = rd; m_wdata = d; end
        end
    end

    // Single compare process: every output, every falling edge.
    always @(negedge i_clk) begin
        chk("wb_en",     {31'b0, o_wb_en}, {31'b0, m_wb_en});
        chk("wb_waddr",  {28'b0, o_wb_waddr}, {28'b0, m_waddr});
        chk("wb_wdata",  o_wb_wdata, m_wdata);
        chk("err",       {31'b0, o_err}, {31'b0, m_err});
        chk("idle",      {31'b0, o_idle}, {31'b0, !m_any_claimed() && !m_wb_en});
        chk("iss_ready", {31'b0, o_iss_ready}, {31'b0, m_iss_ok()});
        chk("lsu_ready", {31'b0, o_lsu_ready}, 32'd1);
        chk("exu_ready", {31'b0, o_exu_ready}, {31'b0, !i_lsu_valid});
        chk("rs1_fwd",   {31'b0, o_rs1_fwd}, {31'b0, m_fwd(i_rs1_addr)});
        chk("rs2_fwd",   {31'b0, o_rs2_fwd}, {31'b0, m_fwd(i_rs2_addr)});
        chk("rs1_fdata", o_rs1_fwd_data, m_fwd(i_rs1_addr) ? m_wdata : '0);
        chk("rs2_fdata", o_rs2_fwd_data, m_fwd(i_rs2_addr) ? m_wdata : '0);
        chk("rs1_busy",  {31'b0, o_rs1_busy},
            {31'b0, m_claimed[i_rs1_addr] && !m_fwd(i_rs1_addr)});
        chk("rs2_busy",  {31'b0, o_rs2_busy},
            {31'b0, m_claimed[i_rs2_addr] && !m_fwd(i_rs2_addr)});
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_in();
        i_iss_valid = 0; i_iss_wen = 0; i_iss_rd = '0;
        i_exu_valid = 0; i_exu_rd = '0; i_exu_data = '0;
        i_lsu_valid = 0; i_lsu_rd = '0; i_lsu_data = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        i_iss_valid = 1; i_iss_wen = 1; i_iss_rd = rd;
    endtask

    task automatic exu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        i_exu_valid = 1; i_exu_rd = rd; i_exu_data = d;
    endtask

    task automatic lsu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        i_lsu_valid = 1; i_lsu_rd = rd; i_lsu_data = d;
    endtask

    // Literal check a little after inputs settle, before the falling edge.
    task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        chk(name, act, exp);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        idle_in();
        i_rs1_addr = '0; i_rs2_addr = '0;
        #12;
        #1 lit("rst_wb_en", {31'b0, o_wb_en}, 0);
        lit("rst_idle", {31'b0, o_idle}, 1);
        lit("rst_err", {31'b0, o_err}, 0);
        i_rst = 1;
        cyc();
        #1 lit("post_rst_iss_ready", {31'b0, o_iss_ready}, 1);
        lit("post_rst_lsu_ready", {31'b0, o_lsu_ready}, 1);

        // Issue x5, ALU result, forward then retire.
        issue(5); i_rs1_addr = 5; i_rs2_addr = 0;
        cyc(); idle_in(); exu(5, 32'hDEADBEEF);
        #1 lit("x5_busy_before", {31'b0, o_rs1_busy}, 1);
        lit("x0_never_busy", {31'b0, o_rs2_busy}, 0);
        cyc(); idle_in();
        #1 lit("x5_wb_en", {31'b0, o_wb_en}, 1);
        lit("x5_waddr", {28'b0, o_wb_waddr}, 5);
        lit("x5_wdata", o_wb_wdata, 32'hDEADBEEF);
        lit("x5_fwd", {31'b0, o_rs1_fwd}, 1);
        lit("x5_fwd_data", o_rs1_fwd_data, 32'hDEADBEEF);
        lit("x5_busy_fwd", {31'b0, o_rs1_busy}, 0);
        cyc();
        #1 lit("x5_busy_after", {31'b0, o_rs1_busy}, 0);
        lit("x5_idle_after", {31'b0, o_idle}, 1);
        lit("x5_wdata_hold", o_wb_wdata, 32'hDEADBEEF);

        // LSU beats EXU in the same cycle.
        issue(3); cyc(); issue(4); cyc(); idle_in();
        lsu(4, 32'hA0A0_0004); exu(3, 32'hB0B0_0003);
        #1 lit("arb_lsu_ready", {31'b0, o_lsu_ready}, 1);
        lit("arb_exu_ready", {31'b0, o_exu_ready}, 0);
        cyc(); i_lsu_valid = 0;
        #1 lit("arb_first_addr", {28'b0, o_wb_waddr}, 4);
        lit("arb_first_data", o_wb_wdata, 32'hA0A0_0004);
        cyc(); idle_in();
        #1 lit("arb_second_en", {31'b0, o_wb_en}, 1);
        lit("arb_second_addr", {28'b0, o_wb_waddr}, 3);
        lit("arb_second_data", o_wb_wdata, 32'hB0B0_0003);
        cyc();

        // WAW stall, then re-claim in the commit cycle.
        issue(7); i_rs1_addr = 7;
        cyc(); exu(7, 32'h0000_0777);
        #1 lit("waw_stall", {31'b0, o_iss_ready}, 0);
        cyc(); i_exu_valid = 0;
        #1 lit("waw_commit_ready", {31'b0, o_iss_ready}, 1);
        cyc(); idle_in();
        #1 lit("waw_reclaimed_busy", {31'b0, o_rs1_busy}, 1);
        lit("waw_not_idle", {31'b0, o_idle}, 0);
        exu(7, 32'h0000_0778);
        cyc(); idle_in();
        cyc(); cyc();

        // Result to x0 is dropped; result to unclaimed x9 raises err.
        lsu(0, 32'h0000_1234);
        cyc(); idle_in();
        #1 lit("x0_no_write", {31'b0, o_wb_en}, 0);
        lit("x0_no_err", {31'b0, o_err}, 0);
        lsu(9, 32'h0000_0999);
        cyc(); idle_in();
        #1 lit("orphan_write", {31'b0, o_wb_en}, 1);
        lit("orphan_addr", {28'b0, o_wb_waddr}, 9);
        lit("orphan_err", {31'b0, o_err}, 1);
        cyc(); cyc();
        #1 lit("err_sticky", {31'b0, o_err}, 1);

        // Back-to-back writes from both sources over several cycles.
        issue(1); cyc(); issue(2); cyc(); issue(6); i_rs2_addr = 2;
        cyc(); idle_in(); exu(1, 32'h11); cyc(); exu(2, 32'h22);
        cyc(); lsu(6, 32'h66); i_exu_valid = 0; cyc(); idle_in();
        cyc(); cyc();

        // Reset mid-cycle with three claims outstanding.
        issue(1); cyc(); issue(2); cyc(); issue(3); cyc(); idle_in();
        lsu(1, 32'h5555_0001); i_rs1_addr = 1;
        cyc(); idle_in();
        #1 i_rst = 0;
        #1 lit("mid_rst_wb_en", {31'b0, o_wb_en}, 0);
        lit("mid_rst_wdata", o_wb_wdata, 0);
        lit("mid_rst_err", {31'b0, o_err}, 0);
        lit("mid_rst_busy", {31'b0, o_rs1_busy}, 0);
        cyc(); cyc();
        i_rst = 1;
        issue(2);
        #1 lit("rel_idle", {31'b0, o_idle}, 1);
        lit("rel_iss_ready", {31'b0, o_iss_ready}, 1);
        lit("rel_lsu_ready", {31'b0, o_lsu_ready}, 1);
        lit("rel_err", {31'b0, o_err}, 0);
        cyc(); idle_in();
        #1 lit("rel_no_stale_write", {31'b0, o_wb_en}, 0);
        exu(2, 32'h2222);
        cyc(); idle_in();
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regf_wbu.md
REGF_WBU -- requirements
Module: regf_wbu

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 4, register address width (RV32E).
REQ-003 Parameter REG_NUM, default 16, number of architectural registers; x0 hardwired zero.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-low.
REQ-006 i_iss_valid  input  1  issuing instruction present.
REQ-007 i_iss_wen  input  1  issuing instruction writes rd.
REQ-008 i_iss_rd  input  ADDR_W  issuing instruction destination.
REQ-009 o_iss_ready  output  1  issue accepted this cycle.
REQ-010 i_exu_valid / i_exu_rd / i_exu_data  input  1 / ADDR_W / DATA_W  ALU result.
REQ-011 o_exu_ready  output  1  ALU result accepted.
REQ-012 i_lsu_valid / i_lsu_rd / i_lsu_data  input  1 / ADDR_W / DATA_W  load result.
REQ-013 o_lsu_ready  output  1  load result accepted.
REQ-014 o_wb_en / o_wb_waddr / o_wb_wdata  output  1 / ADDR_W / DATA_W  register-file write port (drives regfile enable, write address, write data).
REQ-015 i_rs1_addr / i_rs2_addr  input  ADDR_W  hazard query addresses.
REQ-016 o_rs1_busy / o_rs2_busy  output  1  source has uncommitted pending write.
REQ-017 o_rs1_fwd / o_rs2_fwd  output  1  forward valid; o_rs1_fwd_data / o_rs2_fwd_data  output  DATA_W  forwarded value.
REQ-018 o_idle  output  1  no pending writes and o_wb_en low.
REQ-019 o_err  output  1  sticky: result arrived for non-pending register.

Function
REQ-020 Scoreboard: REG_NUM-1 pending bits pend[1..REG_NUM-1]; pend[0] reads constant 0.
REQ-021 Commit event = o_wb_en high in a cycle; the register-file write and clearing of pend[o_wb_waddr] occur at the closing edge of that cycle.
REQ-022 o_iss_ready = ~i_iss_wen | (i_iss_rd==0) | ~pend[i_iss_rd] | (commit event with o_wb_waddr==i_iss_rd); combinational.
REQ-023 Issue handshake (i_iss_valid & o_iss_ready & i_iss_wen & i_iss_rd!=0) sets pend[i_iss_rd] at the edge; when set and clear hit the same register in the same cycle, set wins.
REQ-024 Result arbitration fixed priority LSU over EXU: o_lsu_ready = 1; o_exu_ready = ~i_lsu_valid.
REQ-025 Accepted result in cycle N -> o_wb_en=1, o_wb_waddr=rd, o_wb_wdata=data registered in cycle N+1 (latency 1); no accepted result -> o_wb_en=0 in N+1, addr/data hold previous values.
REQ-026 Accepted result with rd==0: consumed, o_wb_en stays 0, o_err unaffected.
REQ-027 Accepted result with rd!=0 and pend[rd]==0 (excluding a same-cycle issue set): write still performed; o_err set and held until reset.
REQ-028 One write per cycle maximum; back-to-back accepted results produce consecutive o_wb_en cycles.
REQ-029 o_rsX_fwd = o_wb_en & (o_wb_waddr==i_rsX_addr) & (i_rsX_addr!=0); o_rsX_fwd_data = o_wb_wdata, zero when fwd low.
REQ-030 o_rsX_busy = pend[i_rsX_addr] & ~o_rsX_fwd; address 0 never busy.
REQ-031 o_idle = ~|pend & ~o_wb_en.
REQ-032 Handshake signals from the same source are not required to be held after acceptance; inputs sampled only when valid.

Reset
REQ-033 While i_rst low, asynchronously: pend all 0, o_wb_en=0, o_wb_waddr=0, o_wb_wdata=0, o_err=0.
REQ-034 Reset mid-operation discards all pending state and any registered write; first write after release requires a new accepted result; o_idle=1, o_iss_ready=1, o_lsu_ready=1 immediately after reset.

Verification
REQ-035 Issue rd=5 wen=1, then EXU rd=5 data=0xDEADBEEF -> next cycle o_wb_en=1, waddr=5, wdata=0xDEADBEEF; rs1=5 shows fwd=1, busy=0; following cycle busy=0, o_idle=1.
REQ-036 EXU and LSU valid same cycle (rd=3 / rd=4) -> o_lsu_ready=1, o_exu_ready=0; LSU write rd=4 first, EXU rd=3 on next cycle.
REQ-037 pend[7]=1, issue rd=7 -> o_iss_ready=0; in commit cycle of rd=7 reissue rd=7 -> o_iss_ready=1, pend[7]=1 afterward.
REQ-038 Result rd=0 data=0x1234 -> no o_wb_en; result rd=9 with pend[9]=0 -> write occurs, o_err=1 and stays 1.
REQ-039 Three issues pending, assert i_rst low mid-cycle -> outputs zero immediately, o_idle=1 after release, o_err=0.
